mem_port_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the single-port 512x16 synchronous memory.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals between the two access ports and the arbiter.
// slave is the arbiter side; master is the requester/memory side.
interface mem_port_arbiter_if #(
   parameter int AW = 9,
   parameter int DW = 16
);
   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_ack;
   logic [DW-1:0] m0_rdata;
   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_ack;
   logic [DW-1:0] m1_rdata;
   logic          mem_write;
   logic          mem_read;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;
   logic          busy;
   logic          gnt_id;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  mem_dout,
      output m0_ack, m0_rdata, m1_ack, m1_rdata,
      output mem_write, mem_read, mem_addr, mem_din,
      output busy, gnt_id
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output mem_dout,
      input  m0_ack, m0_rdata, m1_ack, m1_rdata,
      input  mem_write, mem_read, mem_addr, mem_din,
      input  busy, gnt_id
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for a single-port 512x16 synchronous memory.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module mem_port_arbiter #(
   parameter int AW = 9,
   parameter int DW = 16
) (
   input logic               clk,
   input logic               rst_b,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          write_q, write_d;
   logic          read_q, read_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] din_q, din_d;
   logic          gnt_q, gnt_d;
   logic          busy_q, busy_d;
   logic [1:0]    ack_q, ack_d;
   logic [DW-1:0] rd0_q, rd0_d;
   logic [DW-1:0] rd1_q, rd1_d;
   logic          any_req;
   logic          win;
   logic          win_we;

   assign any_req = bus.m0_req | bus.m1_req;
   assign win_we  = win ? bus.m1_we : bus.m0_we;

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_q, rr_d;

   // Under contention the port that did not win last time goes first.
   always_comb begin
      if (bus.m0_req && bus.m1_req)
         win = ~rr_q;
      else
         win = bus.m1_req;
   end
`else
   assign win = bus.m1_req & ~bus.m0_req;
`endif

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         read_q  <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         gnt_q   <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= 2'b00;
         rd0_q   <= '0;
         rd1_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_q    <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         read_q  <= read_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
`ifdef ARB_ROUND_ROBIN_EN
         rr_q    <= rr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      read_d  = read_q;
      addr_d  = addr_q;
      din_d   = din_q;
      gnt_d   = gnt_q;
      ack_d   = 2'b00;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
`ifdef ARB_ROUND_ROBIN_EN
      rr_d    = rr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               write_d = win_we;
               read_d  = ~win_we;
               addr_d  = win ? bus.m1_addr : bus.m0_addr;
               din_d   = win ? bus.m1_wdata : bus.m0_wdata;
               gnt_d   = win;
               state_d = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
               rr_d    = win;
`endif
            end
         end
         ACCESS: begin
            write_d = 1'b0;
            read_d  = 1'b0;
            state_d = RESP;
         end
         RESP: begin
            // mem_dout is the read word, or zero after a write.
            if (gnt_q) begin
               ack_d = 2'b10;
               rd1_d = bus.mem_dout;
            end else begin
               ack_d = 2'b01;
               rd0_d = bus.mem_dout;
            end
            state_d = IDLE;
         end
         default: begin
            write_d = 1'b0;
            read_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign bus.mem_write = write_q;
   assign bus.mem_read  = read_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_din   = din_q;
   assign bus.busy      = busy_q;
   assign bus.gnt_id    = gnt_q;
   assign bus.m0_ack    = ack_q[0];
   assign bus.m1_ack    = ack_q[1];
   assign bus.m0_rdata  = rd0_q;
   assign bus.m1_rdata  = rd1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 512x16 memory.
// Expected acks are queued at issue time and popped when an ack appears.
module tb_mem_port_arbiter;

   logic clk;
   logic rst_b;
   int   errors = 0;
   int   checks = 0;

   typedef struct packed {
      logic        id;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mem [512];
   logic [15:0] ref_mem [512];

   mem_port_arbiter_if #(.AW(9), .DW(16)) bus ();

   mem_port_arbiter #(.AW(9), .DW(16)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_write)
         mem[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= bus.mem_read ? mem[bus.mem_addr] : 16'h0000;
   end

   task automatic chk(input string tag,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("rw_excl", {31'd0, bus.mem_read & bus.mem_write}, 0);
      chk("ack_excl", {31'd0, bus.m0_ack & bus.m1_ack}, 0);
      if (bus.m0_ack | bus.m1_ack) begin
         chk("sb_nonempty", {31'd0, sb.size() != 0}, 1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ack_id", {31'd0, bus.m1_ack}, {31'd0, e.id});
            chk("gnt_id", {31'd0, bus.gnt_id}, {31'd0, e.id});
            chk("rdata", {16'd0, bus.m1_ack ? bus.m1_rdata : bus.m0_rdata},
                {16'd0, e.data});
         end
      end
   end

   task automatic drive(input bit id, input bit we,
                        input logic [8:0] a, input logic [15:0] d);
      if (id) begin
         bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_req = 1'b1;
      end else begin
         bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_req = 1'b1;
      end
   endtask

   task automatic expect_ack(input bit id, input bit we,
                             input logic [8:0] a, input logic [15:0] d);
      exp_t e;
      e.id   = id;
      e.data = we ? 16'h0000 : ref_mem[a];
      sb.push_back(e);
      if (we)
         ref_mem[a] = d;
   endtask

   task automatic wait_ack(output int cyc);
      bit got;
      got = 1'b0;
      cyc = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         cyc++;
         got = bus.m0_ack | bus.m1_ack;
      end
      chk("ack_seen", {31'd0, got}, 1);
   endtask

   task automatic single(input bit id, input bit we,
                         input logic [8:0] a, input logic [15:0] d);
      int cyc;
      @(negedge clk);
      drive(id, we, a, d);
      expect_ack(id, we, a, d);
      wait_ack(cyc);
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
      chk("latency", cyc, 3);
   endtask

   initial begin
      int cyc;
      rst_b        = 1'b1;
      bus.m0_req   = 1'b0; bus.m0_we = 1'b0;
      bus.m0_addr  = '0;   bus.m0_wdata = '0;
      bus.m1_req   = 1'b0; bus.m1_we = 1'b0;
      bus.m1_addr  = '0;   bus.m1_wdata = '0;
      #1 rst_b = 1'b0;

      // 1: request held through reset, then released
      drive(0, 1, 9'h1A5, 16'hBEEF);
      repeat (3) @(negedge clk);
      chk("rst_mem_read", {31'd0, bus.mem_read}, 0);
      chk("rst_mem_write", {31'd0, bus.mem_write}, 0);
      chk("rst_m0_ack", {31'd0, bus.m0_ack}, 0);
      chk("rst_busy", {31'd0, bus.busy}, 0);
      chk("rst_gnt", {31'd0, bus.gnt_id}, 0);
      chk("rst_addr", {23'd0, bus.mem_addr}, 0);
      chk("rst_rdata", {16'd0, bus.m0_rdata}, 0);
      expect_ack(0, 1, 9'h1A5, 16'hBEEF);
      rst_b = 1'b1;
      wait_ack(cyc);
      bus.m0_req = 1'b0;
      chk("latency_rst", cyc, 3);

      // 2: read back
      single(0, 0, 9'h1A5, 16'h0000);

      // 4: lone m1 write then read
      single(1, 1, 9'h000, 16'h1234);
      single(1, 0, 9'h000, 16'h0000);

      // 5: reset during ACCESS of an m1 read
      @(negedge clk);
      drive(1, 0, 9'h000, 16'h0000);
      @(negedge clk);
      chk("mid_read_on", {31'd0, bus.mem_read}, 1);
      rst_b = 1'b0;
      bus.m1_req = 1'b0;
      #1;
      chk("mid_read_off", {31'd0, bus.mem_read}, 0);
      chk("mid_busy", {31'd0, bus.busy}, 0);
      chk("mid_m1_ack", {31'd0, bus.m1_ack}, 0);
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      repeat (5) @(negedge clk);
      chk("mid_idle", {31'd0, bus.busy}, 0);

      // 3: contention with both requests held
      @(negedge clk);
      drive(0, 0, 9'h1A5, 16'h0000);
      drive(1, 0, 9'h000, 16'h0000);
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 0; k < 4; k++)
         expect_ack(k[0], 0, k[0] ? 9'h000 : 9'h1A5, 16'h0000);
`else
      for (int k = 0; k < 4; k++)
         expect_ack(0, 0, 9'h1A5, 16'h0000);
      expect_ack(1, 0, 9'h000, 16'h0000);
`endif
      for (int k = 0; k < 4; k++) begin
         wait_ack(cyc);
         chk("b2b_latency", cyc, 3);
      end
      bus.m0_req = 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
      wait_ack(cyc);
      chk("m1_after_m0", cyc, 3);
`endif
      bus.m1_req = 1'b0;

      // 6: address boundaries
      single(0, 1, 9'h1FF, 16'hFFFF);
      single(1, 1, 9'h000, 16'h0001);
      single(0, 0, 9'h1FF, 16'h0000);
      single(1, 0, 9'h000, 16'h0000);

      repeat (4) @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
